// File: rtl/instr_prefetch_queue.sv
// Decoupled instruction fetch front end: issues in-order requests to a variable-latency
// instruction memory and buffers returned words with their PCs for the IF/ID register.
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// RUN   | no stale responses pending (drop_cnt == 0)
// FLUSH | responses from before a redirect still in flight, being discarded
module instr_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    imem_req,
   output logic [31:0]             imem_addr,
   input  logic                    imem_ready,
   input  logic                    imem_rvalid,
   input  logic [31:0]             imem_rdata,
   input  logic                    redirect,
   input  logic [31:0]             redirect_pc,
   input  logic                    hold,
   output logic                    out_valid,
   output logic [31:0]             out_pc,
   output logic [31:0]             out_pcplus4,
   output logic [31:0]             out_instr,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t         state;
   logic [31:0]    fetch_pc;
   logic [31:0]    resp_pc;
   logic [AW:0]    outstanding;
   logic [AW:0]    drop_cnt;
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [31:0]    q_pc    [DEPTH];
   logic [31:0]    q_instr [DEPTH];

   logic [AW+1:0]  credit;
   logic [AW:0]    in_flight;
   logic [31:0]    target_pc;
   logic           accept;
   logic           resp;
   logic           push;
   logic           pop;

   // outstanding + buffered entries never exceed DEPTH, so a push always finds room
   assign credit    = {1'b0, outstanding} + {1'b0, count};
   assign imem_req  = (state != BOOT) && !redirect && (credit < (AW+2)'(DEPTH));
   assign imem_addr = fetch_pc;
   assign accept    = imem_req && imem_ready;
   assign resp      = imem_rvalid && (outstanding != '0);
   assign in_flight = outstanding - CW'(resp);
   assign push      = resp && !redirect && (drop_cnt == '0);
   assign pop       = out_valid && !hold && !redirect;
   assign target_pc = redirect_pc & 32'hFFFF_FFFC;

   assign out_valid   = (count != '0);
   assign out_pc      = out_valid ? q_pc[rd_ptr] : 32'h0;
   assign out_pcplus4 = out_valid ? q_pc[rd_ptr] + 32'd4 : 32'h0;
   assign out_instr   = out_valid ? q_instr[rd_ptr] : 32'h0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         if (imem_rvalid) assert (outstanding != '0);
         outstanding <= outstanding + CW'(accept) - CW'(resp);
         if (redirect) begin
            // every request still in flight belongs to the abandoned path
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
            drop_cnt <= in_flight;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= (in_flight != '0) ? FLUSH : RUN;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
               wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            case (state)
               BOOT:    state <= RUN;
               RUN:     state <= RUN;
               FLUSH:   if (resp && (drop_cnt == CW'(1))) state <= RUN;
               default: state <= BOOT;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && push) begin
         q_pc[wr_ptr]    <= resp_pc;
         q_instr[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a vector table for steady fetch and hold,
// then hand sequences for redirect, flush, reset and PC wrap corner cases.
module tb_instr_prefetch_queue;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        hold = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus4;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 1;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t pending[$];

   typedef struct {
      logic        hold;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [2:0]  exp_count;
   } vec_t;
   vec_t vecs[22];

   always #5 clock = ~clock;

   instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .hold        (hold),
      .out_valid   (out_valid),
      .out_pc      (out_pc),
      .out_pcplus4 (out_pcplus4),
      .out_instr   (out_instr),
      .count       (count)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // memory model drives its response for this cycle, then lets logic settle
   task automatic begin_cycle();
      if (!reset && pending.size() > 0 && pending[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = instr_of(pending[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
   endtask

   task automatic end_cycle();
      if (reset) pending.delete();
      else begin
         if (imem_rvalid) void'(pending.pop_front());
         if (imem_req && imem_ready) pending.push_back('{addr: imem_addr, due: cyc + lat});
      end
      @(posedge clock);
      cyc++;
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         begin_cycle();
         end_cycle();
      end
   endtask

   task automatic do_reset(input int l);
      reset = 1'b1;
      redirect = 1'b0;
      hold = 1'b0;
      lat = l;
      run_cycles(2);
      reset = 1'b0;
      cyc = 1;
   endtask

   task automatic expect_stream(input string name, input logic [31:0] start, input int n,
                                input int budget, input bit no_gap);
      logic [31:0] e;
      int k;
      int b;
      e = start;
      k = 0;
      b = 0;
      while (k < n && b < budget) begin
         begin_cycle();
         if (out_valid) begin
            check({name, "_pc"}, out_pc, e);
            check({name, "_pcplus4"}, out_pcplus4, e + 32'd4);
            check({name, "_instr"}, out_instr, instr_of(e));
            e = e + 32'd4;
            k++;
         end else if (no_gap && k > 0) begin
            check({name, "_gap"}, {31'h0, out_valid}, 32'h1);
         end
         end_cycle();
         b++;
      end
      if (k < n) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d entries expected %0d", name, k, n);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0};
      vecs[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
      vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0};
      vecs[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1};
      vecs[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1};
      vecs[5]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 3'd1};
      vecs[6]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 3'd1};
      vecs[7]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10, 3'd1};
      vecs[8]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd2};
      vecs[9]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 3'd3};
      for (int i = 10; i < 17; i++) vecs[i] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 3'd4};
      vecs[17] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 3'd4};
      vecs[18] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14, 3'd3};
      vecs[19] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h18, 3'd2};
      vecs[20] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h1C, 3'd2};
      vecs[21] = '{1'b0, 1'b1, 32'h2C, 1'b1, 32'h20, 3'd2};

      // steady 1-cycle memory, then hold until full, then release
      do_reset(1);
      for (int i = 0; i < 22; i++) begin
         hold = vecs[i].hold;
         begin_cycle();
         check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
         check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
         check($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
         check($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
         check($sformatf("v%0d_count", i), {29'h0, count}, {29'h0, vecs[i].exp_count});
         check($sformatf("v%0d_instr", i), out_instr,
               vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'h0);
         check($sformatf("v%0d_pcplus4", i), out_pcplus4,
               vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'h0);
         if (i == 16) check("full_outstanding", pending.size(), 32'd0);
         end_cycle();
      end

      // redirect with three requests in flight on a 4-cycle memory
      do_reset(4);
      run_cycles(4);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      begin_cycle();
      check("redir1_req", {31'h0, imem_req}, 32'h0);
      end_cycle();
      redirect = 1'b0;
      begin_cycle();
      check("redir1_count", {29'h0, count}, 32'h0);
      check("redir1_valid", {31'h0, out_valid}, 32'h0);
      end_cycle();
      expect_stream("redir1", 32'h100, 3, 40, 1'b0);

      // second redirect while still flushing
      do_reset(4);
      run_cycles(4);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      begin_cycle();
      end_cycle();
      redirect = 1'b0;
      run_cycles(1);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      begin_cycle();
      check("redir2_rvalid_req", {31'h0, imem_req}, 32'h0);
      end_cycle();
      redirect = 1'b0;
      begin_cycle();
      check("redir2_count", {29'h0, count}, 32'h0);
      end_cycle();
      expect_stream("redir2", 32'h200, 3, 40, 1'b0);

      // redirect coinciding with a response while holding a nearly full queue
      do_reset(1);
      hold = 1'b1;
      run_cycles(5);
      redirect = 1'b1;
      redirect_pc = 32'h303;
      begin_cycle();
      check("redir3_pre_count", {29'h0, count}, 32'h3);
      check("redir3_req", {31'h0, imem_req}, 32'h0);
      check("redir3_pc", out_pc, 32'h0);
      end_cycle();
      redirect = 1'b0;
      begin_cycle();
      check("redir3_count", {29'h0, count}, 32'h0);
      check("redir3_valid", {31'h0, out_valid}, 32'h0);
      check("redir3_instr", out_instr, 32'h0);
      check("redir3_next_req", {31'h0, imem_req}, 32'h1);
      check("redir3_next_addr", imem_addr, 32'h300);
      end_cycle();
      hold = 1'b0;
      expect_stream("redir3", 32'h300, 4, 20, 1'b1);

      // PC wraps through 2^32
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      begin_cycle();
      end_cycle();
      redirect = 1'b0;
      expect_stream("wrap", 32'hFFFF_FFF8, 4, 20, 1'b1);

      // reset with two requests outstanding
      do_reset(4);
      run_cycles(3);
      check("rst_inflight", pending.size(), 32'd2);
      do_reset(4);
      begin_cycle();
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_count", {29'h0, count}, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_pcplus4", out_pcplus4, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      end_cycle();
      begin_cycle();
      check("rst_first_req", {31'h0, imem_req}, 32'h1);
      check("rst_first_addr", imem_addr, 32'h0);
      end_cycle();
      expect_stream("rst", 32'h0, 3, 40, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
